masked_and_pipe: RTL and testbench
==================================

MASKED_AND_PIPE -- requirements
Module: masked_and_pipe

Interface
REQ-001 Parameter D, default 2, is the number of Boolean shares per bit; legal range 2..8.
REQ-002 Parameter W, default 1, is the number of independent bit lanes processed per transaction.
REQ-003 Derived constant RS = D*(D-1)/2 is the fresh random bits per lane; total randomness per transaction is W*RS.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 in_valid  input  1  the input transaction is valid this cycle.
REQ-007 in_ready  output  1  the block accepts the input transaction this cycle.
REQ-008 ina  input  W*D  shares of operand a; lane l, share i at bit l*D+i.
REQ-009 inb  input  W*D  shares of operand b, same layout as ina.
REQ-010 rin  input  W*RS  fresh randomness; lane l, pair index k at bit l*RS+k.
REQ-011 mode  input  1  0 selects AND; 1 selects NAND; sampled with the transaction.
REQ-012 out_valid  output  1  the output shares are valid this cycle.
REQ-013 out_ready  input  1  the consumer accepts the output this cycle.
REQ-014 out  output  W*D  result shares, same layout as ina.

Function
REQ-015 A transfer occurs on a valid/ready pair both high at a rising clk edge; ina, inb, rin, and mode are sampled only on an input transfer.
REQ-016 Pair index for share pair i<j is k(i,j) = i*D - i*(i+1)/2 + (j-i-1), which is a bijection onto 0..RS-1.
REQ-017 Stage 1 registers, per lane, the inner term a_i&b_i and, for every i≠j, the cross term a_i&b_j ^ r_k(min(i,j),max(i,j)).
REQ-018 Stage 1 registers also hold the mode bit and a valid bit s1_v.
REQ-019 The cross-term XOR with randomness is complete before the stage-1 register; no unregistered cross term reaches stage 2.
REQ-020 Stage 2 registers compute c_i = inner_i ^ XOR over j≠i of cross_ij, and invert c_0 only when mode=1.
REQ-021 Stage 2 also holds a valid bit s2_v; out = stage-2 registers and out_valid = s2_v.
REQ-022 For any legal inputs, XOR over i of out lane l equals (a_l AND b_l) when mode=0 and the complement of that when mode=1.
REQ-023 Latency from input transfer to out_valid is exactly 2 cycles when there is no backpressure.
REQ-024 Stage 2 accepts when s2_ready = !s2_v || out_ready.
REQ-025 Stage 1 accepts when s1_ready = !s1_v || s2_ready, and in_ready = s1_ready.
REQ-026 A stage whose contents are not advancing holds its data and valid bit unchanged; while out_valid=1 && out_ready=0, out remains stable.
REQ-027 When the pipeline is full and out_ready=1, an input transfer and an output transfer occur in the same cycle, giving a sustained throughput of 1 transaction per cycle.
REQ-028 At most 2 transactions are in flight; no transaction is dropped or duplicated.
REQ-029 Transactions emerge in order, with the mode bit of each travelling with it.

Reset
REQ-030 While rst_n=0: s1_v=0, s2_v=0, all data registers are 0, and out_valid=0, out=0, in_ready=1.
REQ-031 Reset asserted mid-operation discards all in-flight transactions immediately, without waiting for a clock edge.
REQ-032 Reset deassertion is synchronised externally, and the first input transfer may occur on the first edge with rst_n=1.

Structure
REQ-033 A shared package masked_pkg holds the pair-index function k(i,j) and the RS computation, for reuse by later masked gadgets.
REQ-034 The per-lane datapath (both stages' data registers with enable inputs) is one sub-module, masked_and_lane, instantiated W times.
REQ-035 Handshake and valid control reside in the top level only.
REQ-036 The cross and inner term registers carry keep/dont-touch attributes so synthesis does not merge shares across domains.

Verification
REQ-037 Scenario: D=2, W=1, ina=10, inb=01, rin=1, mode=0, out_ready=1 -> 2 cycles later out_valid=1, out shares (c0,c1)=(0,1), XOR=1.
REQ-038 Scenario: same stimulus with mode=1 -> out shares (1,1), XOR=0.
REQ-039 Scenario: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 on the third, out held stable; after out_ready=1, all three emerge in order.
REQ-040 Scenario: continuous in_valid and out_ready for 16 transactions -> one output per cycle after a 2-cycle fill.
REQ-041 Scenario: rst_n pulsed low with 2 transactions in flight -> out_valid=0 asynchronously, and only post-reset inputs emerge afterwards.
REQ-042 Scenario: D=3, W=4, exhaustive unmasked a/b combinations with random shares and rin -> XOR of output shares matches AND/NAND for every lane.

Source files
------------

// File: rtl/masked_pkg.sv
// Helpers shared by the masked (Boolean-shared) gadgets: randomness count and
// the mapping from an unordered share pair to its randomness bit.
package masked_pkg;

  function automatic int unsigned rs_of(input int unsigned d);
    return d * (d - 1) / 2;
  endfunction

  // Only valid for i < j; enumerates pairs row by row.
  function automatic int unsigned pair_idx(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned d);
    return i * d - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/masked_and_lane.sv
// One bit lane of the two-stage masked AND: stage 1 holds inner and refreshed
// cross products, stage 2 compresses them into the output shares.
module masked_and_lane
  import masked_pkg::*;
#(
  parameter int unsigned D  = 2,
  parameter int unsigned RS = rs_of(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s1_en,
  input  logic          s2_en,
  input  logic [D-1:0]  a,
  input  logic [D-1:0]  b,
  input  logic [RS-1:0] r,
  input  logic          inv,
  output logic [D-1:0]  c
);

  // Kept as distinct registers so synthesis cannot fold shares together
  // before the randomness has been registered in.
  (* keep = "true", dont_touch = "true" *) logic [D-1:0]         inner_q;
  (* keep = "true", dont_touch = "true" *) logic [D-1:0][D-1:0]  cross_q;

  logic [D-1:0]        inner_d;
  logic [D-1:0][D-1:0] cross_d;
  logic [D-1:0]        c_d;

  assign inner_d = a & b;

  // The diagonal of the cross matrix is a constant zero so that every share's
  // XOR-reduce can run over a whole row.
  for (genvar i = 0; i < D; i++) begin : g_row
    for (genvar j = 0; j < D; j++) begin : g_col
      if (i < j) begin : g_up
        localparam int unsigned K = pair_idx(i, j, D);
        assign cross_d[i][j] = (a[i] & b[j]) ^ r[K];
      end else if (i > j) begin : g_lo
        localparam int unsigned K = pair_idx(j, i, D);
        assign cross_d[i][j] = (a[i] & b[j]) ^ r[K];
      end else begin : g_diag
        assign cross_d[i][j] = 1'b0;
      end
    end

    if (i == 0) begin : g_inv
      assign c_d[i] = inner_q[i] ^ (^cross_q[i]) ^ inv;
    end else begin : g_plain
      assign c_d[i] = inner_q[i] ^ (^cross_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_q <= '0;
      cross_q <= '0;
      c       <= '0;
    end else begin
      if (s1_en) begin
        inner_q <= inner_d;
        cross_q <= cross_d;
      end
      if (s2_en) begin
        c <= c_d;
      end
    end
  end

endmodule

// File: rtl/masked_and_pipe.sv
// Two-stage valid/ready pipelined masked AND/NAND over W independent lanes of
// D Boolean shares each.
module masked_and_pipe
  import masked_pkg::*;
#(
  parameter int unsigned D = 2,
  parameter int unsigned W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*D-1:0]       ina,
  input  logic [W*D-1:0]       inb,
  input  logic [W*rs_of(D)-1:0] rin,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*D-1:0]       out
);

  localparam int unsigned RS = rs_of(D);

  logic s1_v, s2_v, s1_mode;
  logic s1_ready, s2_ready;
  logic s1_en, s2_en;

  assign s2_ready  = !s2_v || out_ready;
  assign s1_ready  = !s1_v || s2_ready;
  assign in_ready  = s1_ready;
  assign s1_en     = in_valid && s1_ready;
  assign s2_en     = s1_v && s2_ready;
  assign out_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_mode <= 1'b0;
    end else begin
      if (s1_ready) s1_v <= in_valid;
      if (s2_ready) s2_v <= s1_v;
      if (s1_en)    s1_mode <= mode;
    end
  end

  for (genvar l = 0; l < W; l++) begin : g_lane
    masked_and_lane #(
      .D  (D),
      .RS (RS)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .s1_en (s1_en),
      .s2_en (s2_en),
      .a     (ina[l*D +: D]),
      .b     (inb[l*D +: D]),
      .r     (rin[l*RS +: RS]),
      .inv   (s1_mode),
      .c     (out[l*D +: D])
    );
  end

endmodule

// File: tb/tb_masked_and_pipe.sv
// Self-checking bench: a small (D=2,W=1) and a wide (D=3,W=4) instance, each
// scoreboarded against a share-level behavioural model.
module tb_masked_and_pipe;

  localparam int DS = 2, WS = 1, RSS = 1;
  localparam int DB = 3, WB = 4, RSB = 3;

  typedef struct {
    logic [63:0] shares;
    logic [7:0]  unm;
    int          acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                s_in_valid = 0, s_in_ready, s_mode = 0;
  logic                s_out_valid, s_out_ready = 0;
  logic [WS*DS-1:0]    s_ina = '0, s_inb = '0, s_out;
  logic [WS*RSS-1:0]   s_rin = '0;

  logic                b_in_valid = 0, b_in_ready, b_mode = 0;
  logic                b_out_valid, b_out_ready = 0;
  logic [WB*DB-1:0]    b_ina = '0, b_inb = '0, b_out;
  logic [WB*RSB-1:0]   b_rin = '0;

  masked_and_pipe #(.D(DS), .W(WS)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ina(s_ina), .inb(s_inb), .rin(s_rin), .mode(s_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out));

  masked_and_pipe #(.D(DB), .W(WB)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ina(b_ina), .inb(b_inb), .rin(b_rin), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out));

  int   tests = 0, fails = 0, cyc = 0, s_nout = 0;
  bit   rnd_s = 0, rnd_b = 0;
  ent_t sq[$], bq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Share i = a_i & (XOR of all b shares) ^ every r shared with another share.
  function automatic logic [63:0] model(input int d, input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] r,
                                        input logic m);
    logic [63:0] res = '0;
    int rs = d * (d - 1) / 2;
    for (int l = 0; l < w; l++) begin
      logic bp = 1'b0;
      for (int j = 0; j < d; j++) bp ^= b[l*d+j];
      for (int i = 0; i < d; i++) begin
        logic c = a[l*d+i] & bp;
        for (int j = 0; j < d; j++) begin
          if (j != i) begin
            int k = 0, idx = 0;
            for (int p = 0; p < d; p++)
              for (int q = p + 1; q < d; q++) begin
                if ((p == i && q == j) || (p == j && q == i)) idx = k;
                k++;
              end
            c ^= r[l*rs+idx];
          end
        end
        if (i == 0) c ^= m;
        res[l*d+i] = c;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] lane_xor(input int d, input int w, input logic [63:0] v);
    logic [7:0] u = '0;
    for (int l = 0; l < w; l++)
      for (int i = 0; i < d; i++) u[l] ^= v[l*d+i];
    return u;
  endfunction

  function automatic logic [7:0] unm(input int d, input int w, input logic [63:0] a,
                                     input logic [63:0] b, input logic m);
    logic [7:0] pa = lane_xor(d, w, a), pb = lane_xor(d, w, b), u = '0;
    for (int l = 0; l < w; l++) u[l] = (pa[l] & pb[l]) ^ m;
    return u;
  endfunction

  function automatic logic [63:0] mk_shares(input int d, input int w, input logic [7:0] val);
    logic [63:0] v = {$urandom, $urandom};
    for (int l = 0; l < w; l++) begin
      logic p = val[l];
      for (int i = 1; i < d; i++) p ^= v[l*d+i];
      v[l*d] = p;
    end
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_s) s_out_ready = 1'($urandom_range(0, 1));
    if (rnd_b) b_out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic ev;
    ent_t e;
    if (rst_n) begin
      ev = (sq.size() > 0) && (sq[0].acc < cyc);
      chk("s_out_valid", s_out_valid, ev);
      chk("s_in_ready", s_in_ready, (sq.size() < 2) || s_out_ready);
      if (ev && s_out_valid) begin
        chk("s_out_shares", s_out, sq[0].shares);
        chk("s_out_unmasked", lane_xor(DS, WS, s_out), sq[0].unm);
        if (s_out_ready) begin
          void'(sq.pop_front());
          s_nout++;
        end
      end
      if (s_in_valid && s_in_ready) begin
        e.shares = model(DS, WS, s_ina, s_inb, s_rin, s_mode);
        e.unm    = unm(DS, WS, s_ina, s_inb, s_mode);
        e.acc    = cyc + 1;
        sq.push_back(e);
      end

      ev = (bq.size() > 0) && (bq[0].acc < cyc);
      chk("b_out_valid", b_out_valid, ev);
      chk("b_in_ready", b_in_ready, (bq.size() < 2) || b_out_ready);
      if (ev && b_out_valid) begin
        chk("b_out_shares", b_out, bq[0].shares);
        chk("b_out_unmasked", lane_xor(DB, WB, b_out), bq[0].unm);
        if (b_out_ready) void'(bq.pop_front());
      end
      if (b_in_valid && b_in_ready) begin
        e.shares = model(DB, WB, b_ina, b_inb, b_rin, b_mode);
        e.unm    = unm(DB, WB, b_ina, b_inb, b_mode);
        e.acc    = cyc + 1;
        bq.push_back(e);
      end
    end
  end

  task automatic s_send(input logic [1:0] a, input logic [1:0] b, input logic r, input logic m);
    bit done = 0;
    s_ina = a; s_inb = b; s_rin = r; s_mode = m; s_in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_in_ready) done = 1;
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    if (!done) chk("s_send_timeout", 0, 1);
  endtask

  task automatic b_send(input logic [11:0] a, input logic [11:0] b, input logic [11:0] r,
                        input logic m);
    bit done = 0;
    b_ina = a; b_inb = b; b_rin = r; b_mode = m; b_in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (b_in_ready) done = 1;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    if (!done) chk("b_send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (sq.size() > 0 || bq.size() > 0); t++) @(posedge clk);
    #1;
    chk("drain_small", sq.size(), 0);
    chk("drain_big", bq.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_out_valid"}, s_out_valid, 0);
    chk({tag, "_s_out"}, s_out, 0);
    chk({tag, "_s_in_ready"}, s_in_ready, 1);
    chk({tag, "_b_out_valid"}, b_out_valid, 0);
    chk({tag, "_b_out"}, b_out, 0);
    chk({tag, "_b_in_ready"}, b_in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ta, tb_;
    logic       tr, tm;
    logic [WS*DS-1:0] hold;
    int c0, n0;

    // Model pinned by hand-derived values.
    chk("pin_d2_and",  model(2, 1, 64'h1, 64'h2, 64'h1, 1'b0), 64'h2);
    chk("pin_d2_nand", model(2, 1, 64'h1, 64'h2, 64'h1, 1'b1), 64'h3);
    chk("pin_d3_r0",   model(3, 1, 64'h7, 64'h1, 64'h1, 1'b0), 64'h4);

    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Worked example, AND then NAND; first transfer on first edge out of reset.
    s_out_ready = 1'b1;
    s_ina = 2'b01; s_inb = 2'b10; s_rin = 1'b1; s_mode = 1'b0; s_in_valid = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0;
    chk("lat_not_yet", s_out_valid, 0);
    @(posedge clk); #1;
    chk("ex_and_valid", s_out_valid, 1);
    chk("ex_and_out", s_out, 2'b10);
    chk("ex_and_xor", s_out[0] ^ s_out[1], 1);
    s_mode = 1'b1; s_in_valid = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ex_nand_valid", s_out_valid, 1);
    chk("ex_nand_out", s_out, 2'b11);
    chk("ex_nand_xor", s_out[0] ^ s_out[1], 0);
    drain();

    // Backpressure: two accepted, third blocked, output held.
    s_out_ready = 1'b0;
    repeat (2) s_send(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    ta = 2'($urandom); tb_ = 2'($urandom); tr = 1'($urandom); tm = 1'($urandom);
    s_ina = ta; s_inb = tb_; s_rin = tr; s_mode = tm; s_in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", s_in_ready, 0);
    chk("bp_out_valid", s_out_valid, 1);
    hold = s_out;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_stable", s_out, hold);
    end
    @(posedge clk); #1 s_out_ready = 1'b1;
    s_send(ta, tb_, tr, tm);
    drain();

    // Sustained throughput.
    n0 = s_nout;
    c0 = cyc;
    repeat (16) s_send(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    chk("tput_in_cycles", cyc - c0, 16);
    repeat (2) @(posedge clk);
    #1 chk("tput_out_count", s_nout - n0, 16);
    drain();

    // Asynchronous reset with two transactions in flight.
    s_out_ready = 1'b0;
    repeat (2) s_send(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    sq.delete();
    bq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    s_out_ready = 1'b1;
    repeat (3) s_send(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Random traffic with random backpressure on the small instance.
    rnd_s = 1;
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      s_send(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end
    rnd_s = 0;
    @(posedge clk); #1 s_out_ready = 1'b1;
    drain();

    // Wide instance: every unmasked a/b combination over 4 lanes, both modes.
    rnd_b = 1;
    for (int pat = 0; pat < 256; pat++)
      for (int m = 0; m < 2; m++)
        b_send(12'(mk_shares(DB, WB, 8'(pat & 15))), 12'(mk_shares(DB, WB, 8'(pat >> 4))),
               12'($urandom), 1'(m));
    rnd_b = 0;
    @(posedge clk); #1 b_out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
